// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: discards settle samples after start, writes a frame of
// {left,right} pairs into a sample buffer, then holds frame_ready until the FFT acks.
module adc_capture_ctrl #(
  parameter int FRAME_LEN = 1024,
  parameter int ADDR_W    = 10,
  parameter int SETTLE_N  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              cont,
  input  logic              din_valid,
  input  logic [19:0]       dig_l,
  input  logic [19:0]       dig_r,
  input  logic              fft_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [39:0]       wr_data,
  output logic              ok_to_sample,
  output logic              frame_ready,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       frame_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // The settle counter only needs to reach SETTLE_N-1; the SETTLE_N-th valid leaves the state.
  localparam int              SW          = (SETTLE_N < 2) ? 1 : $clog2(SETTLE_N);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'((SETTLE_N > 0) ? SETTLE_N - 1 : 0);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(FRAME_LEN - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [39:0]       wr_data_q, wr_data_d;
  logic              ok_q, ok_d;
  logic              frame_ready_q, frame_ready_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    settle_d      = settle_q;
    wr_en_d       = 1'b0;
    ok_d          = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_ready_d = frame_ready_q;
    overrun_d     = overrun_q;
    frame_cnt_d   = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          idx_d     = '0;
          settle_d  = '0;
          overrun_d = 1'b0;
          state_d   = (SETTLE_N == 0) ? S_CAPTURE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (din_valid) begin
          if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            state_d  = S_CAPTURE;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (din_valid) begin
          wr_en_d   = 1'b1;
          ok_d      = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = {dig_l, dig_r};
          idx_d     = idx_q + 1'b1;
          // frame_ready rises together with the final write of the frame
          if (idx_q == IDX_LAST) begin
            idx_d         = '0;
            frame_ready_d = 1'b1;
            state_d       = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (din_valid) begin
          overrun_d = 1'b1;
        end
        if (fft_ack) begin
          frame_ready_d = 1'b0;
          frame_cnt_d   = frame_cnt_q + 16'd1;
          state_d       = (cont && !stop) ? S_CAPTURE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      settle_q      <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      ok_q          <= 1'b0;
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      settle_q      <= settle_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      ok_q          <= ok_d;
      frame_ready_q <= frame_ready_d;
      overrun_q     <= overrun_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign ok_to_sample = ok_q;
  assign frame_ready  = frame_ready_q;
  assign overrun      = overrun_q;
  assign frame_cnt    = frame_cnt_q;
  assign busy         = (state_q != S_IDLE);

endmodule
